// File: rtl/sfu_seq.sv
// sfu_seq: sequences psum SRAM reads into the per-column SFU array, applies
// ReLU through the SFU loopback and writes each finished pixel row to output
// SRAM. One start pulse processes NUM_O pixels of NUM_KIJ partial sums each.
// Build option: define SFU_SEQ_RELU_EN to include the ReLU pass; when it is
// undefined the raw accumulated sums are written (one cycle less per pixel).
module sfu_seq #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned NUM_KIJ = 9,
  parameter int unsigned NUM_O   = 16,
  parameter int unsigned PSUM_AW = 8,
  parameter int unsigned OUT_AW  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     psum_ren,
  output logic [PSUM_AW-1:0]       psum_addr,
  input  logic [col*psum_bw-1:0]   psum_rdata,
  output logic                     sfu_clr,
  output logic                     acc_valid,
  output logic                     relu_valid,
  output logic [col*psum_bw-1:0]   sfu_in,
  input  logic [col*psum_bw-1:0]   sfu_out,
  output logic                     out_wen,
  output logic [OUT_AW-1:0]        out_addr,
  output logic [col*psum_bw-1:0]   out_wdata
);

  localparam int unsigned KIJ_W = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;
  localparam int unsigned O_W   = (NUM_O > 1) ? $clog2(NUM_O) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_DRAIN,
    S_RELU,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state;
  logic [KIJ_W-1:0] kij;
  logic [O_W-1:0]   o_idx;

  // psum row address for a kernel position / pixel pair
  function automatic logic [PSUM_AW-1:0] rd_addr(input logic [KIJ_W-1:0] k,
                                                 input logic [O_W-1:0]   oi);
    return PSUM_AW'(32'(k) * NUM_O + 32'(oi));
  endfunction

  // Sequencer FSM; every control output is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      kij       <= '0;
      o_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      psum_ren  <= 1'b0;
      psum_addr <= '0;
      sfu_clr   <= 1'b0;
      acc_valid <= 1'b0;
      out_wen   <= 1'b0;
      out_addr  <= '0;
`ifdef SFU_SEQ_RELU_EN
      relu_valid <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      sfu_clr   <= 1'b0;
      psum_ren  <= 1'b0;
      out_wen   <= 1'b0;
      // read data arrives one cycle after the request, so accumulate then
      acc_valid <= psum_ren;
`ifdef SFU_SEQ_RELU_EN
      relu_valid <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CLR;
            busy    <= 1'b1;
            sfu_clr <= 1'b1;
            kij     <= '0;
          end
        end
        S_CLR: begin
          state     <= S_READ;
          kij       <= '0;
          psum_ren  <= 1'b1;
          psum_addr <= rd_addr('0, o_idx);
        end
        S_READ: begin
          if (kij == KIJ_W'(NUM_KIJ - 1)) begin
            state <= S_DRAIN;
            kij   <= '0;
          end else begin
            kij       <= kij + KIJ_W'(1);
            psum_ren  <= 1'b1;
            psum_addr <= rd_addr(kij + KIJ_W'(1), o_idx);
          end
        end
        S_DRAIN: begin
`ifdef SFU_SEQ_RELU_EN
          state      <= S_RELU;
          relu_valid <= 1'b1;
`else
          state    <= S_WRITE;
          out_wen  <= 1'b1;
          out_addr <= OUT_AW'(o_idx);
`endif
        end
`ifdef SFU_SEQ_RELU_EN
        S_RELU: begin
          state    <= S_WRITE;
          out_wen  <= 1'b1;
          out_addr <= OUT_AW'(o_idx);
        end
`endif
        S_WRITE: begin
          if (o_idx == O_W'(NUM_O - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
            o_idx <= '0;
          end else begin
            state   <= S_CLR;
            sfu_clr <= 1'b1;
            o_idx   <= o_idx + O_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          kij   <= '0;
          o_idx <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SFU_SEQ_RELU_EN
  assign relu_valid = 1'b0;
`endif

  // SFU input mux: psum stream while accumulating, SFU loopback during ReLU
  always_comb begin
    sfu_in = '0;
    if (acc_valid) begin
      sfu_in = psum_rdata;
    end else if (relu_valid) begin
      sfu_in = sfu_out;
    end
  end

  // Output row is whatever the SFUs hold in the write cycle
  assign out_wdata = out_wen ? sfu_out : '0;

endmodule
